vending_coin_arbiter: RTL and testbench
=======================================

Name: vending_coin_arbiter

Overview:
Shares one vending_machine_mealy instance between N_REQ coin slots. The block grants one slot ownership of the machine for a whole purchase, using round-robin selection when idle. It serializes that slot's coins onto the machine's 2-bit coin input and routes the sell and change results back to the owning slot. It also mirrors the machine's credit internally, so it knows when a purchase completes and can flag any disagreement with the machine.

Parameters:
N_REQ, 4, number of coin slots (2..8)
PRICE, 3, item price in half-units (3 = 1.5); must match the machine
OW, $clog2(N_REQ), owner index width (derived; not overridable)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
req  in  N_REQ  per-slot coin valid; slot i holds req[i] and its coin_in slice until the handshake
coin_in  in  2*N_REQ  slot i coin at [2i+1:2i]; 00 none, 01 0.5, 10 1.0, 11 illegal
ready  out  N_REQ  per-slot accept, combinational; handshake = req[i] & ready[i] at a rising edge
coin  out  2  registered coin to the machine
m_sell  in  1  machine sell output (Mealy, valid in the cycle coin is driven)
m_change  in  2  machine change output (00 none, 01 0.5)
done  out  N_REQ  registered 1-cycle pulse to the owner on purchase completion
change_o  out  2  registered change value, valid with done
busy  out  1  a slot owns the machine
owner  out  OW  current owner index; 0 when idle
illegal  out  1  1-cycle pulse: an illegal coin was accepted and dropped
mismatch  out  1  sticky: machine result disagreed with mirrored credit

Behaviour:
- Valid request: req[i]=1 and coin_in slice is 01, 10 or 11. A slice of 00 is ignored everywhere, never handshaken.
- Reset (rstn=0 at an edge): state=IDLE, coin=00, done=0, change_o=00, illegal=0, mismatch=0, credit=0, owner=0, rr_ptr=0. Reset mid-purchase discards the purchase; the machine shares the reset.
- States:
  - IDLE: no owner.
  - OWN: accepting coins from the owner.
  - SETTLE: final coin is in the machine; waiting to sample the result.
- IDLE rules:
  - Grant goes to the first slot with a valid request, searching from rr_ptr upward with wrap.
  - ready is 1 only for that slot.
  - On handshake: owner<=i, busy<=1, state<=OWN. The coin is processed as in OWN, so a first coin can complete the purchase directly.
- OWN rules:
  - ready[owner]=1; all other ready bits are 0. Requests from other slots are held off with no loss.
- Coin processing on handshake, value v (01→1, 10→2):
  - coin<=coin_in slice.
  - If credit+v < PRICE: credit<=credit+v, stay in OWN.
  - Otherwise: exp_change<=credit+v-PRICE (0 or 1), credit<=0, state<=SETTLE.
- Illegal coin on handshake: coin<=00, illegal pulses the next cycle, credit and state are unchanged. An illegal first coin in IDLE still grants ownership.
- coin returns to 00 on every edge without a handshake, so each coin is driven for exactly one cycle.
- Throughput: 1 coin per cycle while in OWN.
- SETTLE (one cycle): the machine's Mealy outputs for the final coin are present. At the end-of-cycle edge:
  - done[owner]<=1, change_o<=exp_change (from the mirror, not from the machine).
  - rr_ptr<=owner+1 mod N_REQ.
  - owner<=0, busy<=0, state<=IDLE.
  - ready=0 throughout SETTLE.
- Latency: final-coin handshake at edge E0 → coin valid E0..E1 → done/change_o valid E1..E2. A new grant is possible at edge E2 at the earliest.
- Mismatch check:
  - In SETTLE, set mismatch if m_sell!=1 or m_change!=exp_change.
  - In any other cycle, set mismatch if m_sell=1 or m_change!=00.
  - mismatch clears only on reset.
- Credit width: $clog2(PRICE+2) bits, so it never overflows.

Test Plan:
- Slot 0 inserts 01,01,01 on consecutive cycles → coin 01 for 3 cycles; done[0] pulses 1 cycle after the last coin is driven; change_o=00; busy drops; mismatch=0.
- Slot 1 inserts 10,01,10 → purchase completes on the 2nd coin (credit 3): done[1] pulses with change_o=00; the 3rd coin waits (ready[1]=0 in SETTLE), then starts a new purchase (credit 2). Separately, 10,10 → done[1] with change_o=01.
- Slots 0 and 2 request together from reset → slot 0 is granted; ready[2]=0 until slot 0 completes; slot 2 is granted next; after slot 2 completes, a simultaneous 0/2 request grants slot 0 (rr_ptr=3 wraps).
- Owner sends 11 mid-purchase → coin=00, illegal pulses once, credit is unchanged, and the purchase completes normally afterwards.
- Bench forces m_sell=0 during SETTLE, or m_sell=1 during OWN → mismatch=1 and stays set until rstn=0.
- rstn=0 for 1 cycle with credit=2 → next cycle busy=0, coin=00, owner=0, rr_ptr=0, and no done pulse.

Source files
------------

// File: rtl/vending_coin_arbiter.sv
// vending_coin_arbiter: shares one vending_machine_mealy among N_REQ coin slots.
// Round-robin grant, one owner per purchase, mirrored credit for completion and cross-check.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   req, coin_in       per-slot coin valid and 2-bit coin slices
//   ready              per-slot accept (combinational)
//   coin               registered coin to the machine
//   m_sell, m_change   machine Mealy results
//   done, change_o     purchase-complete pulse to the owner, with change
//   busy, owner        ownership status
//   illegal            pulse when an 11 coin is accepted and dropped
//   mismatch           sticky disagreement between machine and mirror
module vending_coin_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int PRICE = 3,
    localparam int OW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] coin_in,
    output logic [N_REQ-1:0]   ready,
    output logic [1:0]         coin,
    input  logic               m_sell,
    input  logic [1:0]         m_change,
    output logic [N_REQ-1:0]   done,
    output logic [1:0]         change_o,
    output logic               busy,
    output logic [OW-1:0]      owner,
    output logic               illegal,
    output logic               mismatch
);

    localparam int CW = $clog2(PRICE + 2);
    localparam int JW = OW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] OWN    = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    credit;
    logic [1:0]       exp_change;
    logic [OW-1:0]    rr_ptr;

    logic [N_REQ-1:0] valid;
    logic             gnt_found;
    logic [OW-1:0]    gnt_idx;
    logic [JW-1:0]    j;
    logic [OW-1:0]    sel;
    logic [1:0]       sel_coin;
    logic             hs;
    logic [CW-1:0]    coin_val;
    logic [CW-1:0]    sum;

    // A 00 slice is not a request at all.
    always_comb begin
        valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            valid[i] = req[i] & (coin_in[2*i +: 2] != 2'b00);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = {1'b0, rr_ptr} + JW'(k);
            if (j >= JW'(N_REQ)) begin
                j = j - JW'(N_REQ);
            end
            if (!gnt_found && valid[j[OW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = j[OW-1:0];
            end
        end
    end

    assign sel      = (state == IDLE) ? gnt_idx : owner;
    assign sel_coin = coin_in[{sel, 1'b0} +: 2];
    assign busy     = (state != IDLE);

    always_comb begin
        ready = '0;
        hs    = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                ready[gnt_idx] = gnt_found;
                hs             = gnt_found;
            end
            (state == OWN): begin
                ready[owner] = 1'b1;
                hs           = valid[owner];
            end
            default: ;
        endcase
    end

    always_comb begin
        coin_val = '0;
        unique case (1'b1)
            (sel_coin == 2'b01): coin_val = CW'(1);
            (sel_coin == 2'b10): coin_val = CW'(2);
            default:             coin_val = '0;
        endcase
        sum = credit + coin_val;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            credit     <= '0;
            exp_change <= 2'b00;
            rr_ptr     <= '0;
            owner      <= '0;
            coin       <= 2'b00;
            done       <= '0;
            change_o   <= 2'b00;
            illegal    <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            coin     <= 2'b00;
            done     <= '0;
            change_o <= 2'b00;
            illegal  <= 1'b0;

            // Machine must sell exactly in SETTLE, with the mirrored change.
            if (state == SETTLE) begin
                if (!m_sell || (m_change != exp_change)) begin
                    mismatch <= 1'b1;
                end
            end else if (m_sell || (m_change != 2'b00)) begin
                mismatch <= 1'b1;
            end

            if (state == SETTLE) begin
                done[owner] <= 1'b1;
                change_o    <= exp_change;
                rr_ptr      <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                owner       <= '0;
                state       <= IDLE;
            end else if (hs) begin
                if (state == IDLE) begin
                    owner <= gnt_idx;
                    state <= OWN;
                end
                // A first coin can finish the purchase, overriding OWN.
                if (sel_coin == 2'b11) begin
                    illegal <= 1'b1;
                end else begin
                    coin <= sel_coin;
                    if (sum < CW'(PRICE)) begin
                        credit <= sum;
                    end else begin
                        exp_change <= 2'(sum - CW'(PRICE));
                        credit     <= '0;
                        state      <= SETTLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vending_coin_arbiter.sv
// tb_vending_coin_arbiter: directed vector bench for vending_coin_arbiter.
// Includes a small behavioural vending machine (price 1.5) driving m_sell/m_change.
module tb_vending_coin_arbiter;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic [7:0] coin_in;
    logic [3:0] ready;
    logic [1:0] coin;
    logic       m_sell;
    logic [1:0] m_change;
    logic [3:0] done;
    logic [1:0] change_o;
    logic       busy;
    logic [1:0] owner;
    logic       illegal;
    logic       mismatch;

    int tests;
    int failed;

    logic       frc_en;
    logic       frc_val;
    logic [2:0] m_cred;
    logic [2:0] mv;
    logic [2:0] tot;
    logic       mdl_sell;
    logic [1:0] mdl_chg;

    vending_coin_arbiter #(.N_REQ(4), .PRICE(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .coin_in  (coin_in),
        .ready    (ready),
        .coin     (coin),
        .m_sell   (m_sell),
        .m_change (m_change),
        .done     (done),
        .change_o (change_o),
        .busy     (busy),
        .owner    (owner),
        .illegal  (illegal),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference machine: sells once credit reaches 3 half-units.
    always_comb begin
        mv       = (coin == 2'b01) ? 3'd1 : (coin == 2'b10) ? 3'd2 : 3'd0;
        tot      = m_cred + mv;
        mdl_sell = (tot >= 3'd3);
        mdl_chg  = (tot == 3'd4) ? 2'b01 : 2'b00;
    end

    always @(posedge clk) begin
        if (!rstn) m_cred <= 3'd0;
        else       m_cred <= mdl_sell ? 3'd0 : tot;
    end

    assign m_sell   = frc_en ? frc_val : mdl_sell;
    assign m_change = mdl_chg;

    typedef struct {
        logic       rstn;
        logic [3:0] req;
        logic [7:0] cin;
        logic [1:0] frc;
        logic [3:0] rdy;
        logic [1:0] coin;
        logic [3:0] done;
        logic [1:0] chg;
        logic       busy;
        logic [1:0] own;
        logic       ill;
        logic       mm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int rq, input int ci,
                                input int fr, input int rd, input int co,
                                input int dn, input int ch, input int bs,
                                input int ow, input int il, input int mm);
        vec_t v;
        v.rstn = r[0];
        v.req  = rq[3:0];
        v.cin  = ci[7:0];
        v.frc  = fr[1:0];
        v.rdy  = rd[3:0];
        v.coin = co[1:0];
        v.done = dn[3:0];
        v.chg  = ch[1:0];
        v.busy = bs[0];
        v.own  = ow[1:0];
        v.ill  = il[0];
        v.mm   = mm[0];
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // frc: 0 = machine model, 1 = force m_sell=0, 2 = force m_sell=1.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rstn    = v.rstn;
        req     = v.req;
        coin_in = v.cin;
        frc_en  = (v.frc != 2'd0);
        frc_val = (v.frc == 2'd2);
        #1;
        chk("ready", idx, 8'(ready), 8'(v.rdy));
        @(posedge clk);
        #1;
        frc_en = 1'b0;
        chk("coin",     idx, 8'(coin),     8'(v.coin));
        chk("done",     idx, 8'(done),     8'(v.done));
        chk("change_o", idx, 8'(change_o), 8'(v.chg));
        chk("busy",     idx, 8'(busy),     8'(v.busy));
        chk("owner",    idx, 8'(owner),    8'(v.own));
        chk("illegal",  idx, 8'(illegal),  8'(v.ill));
        chk("mismatch", idx, 8'(mismatch), 8'(v.mm));
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rstn    = 1'b0;
        req     = '0;
        coin_in = '0;
        frc_en  = 1'b0;
        frc_val = 1'b0;

        //                 rst req cin  frc rdy coin done chg busy own ill mm
        // reset state
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // slot0: 01,01,01
        tbl.push_back(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // slot1: 10,01 completes; 3rd coin waits then opens a new purchase
        tbl.push_back(mk(1, 2, 'h08, 0, 2, 2, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h04, 0, 2, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h08, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 'h08, 0, 2, 2, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h04, 0, 2, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        // slot1: 10,10 gives change 01
        tbl.push_back(mk(1, 2, 'h08, 0, 2, 2, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h08, 0, 2, 2, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        // slots 0 and 2 from reset, round-robin with wrap
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h11, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h12, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4, 'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 'h10, 0, 4, 1, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 4, 'h20, 0, 4, 2, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 5, 'h11, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 'h11, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h02, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // illegal coin mid-purchase on slot1
        tbl.push_back(mk(1, 2, 'h04, 0, 2, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h0C, 0, 2, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 2, 'h04, 0, 2, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 'h04, 0, 2, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        // illegal first coin from idle still grants slot0
        tbl.push_back(mk(1, 1, 'h03, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 'h02, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // req with a 00 slice is ignored
        tbl.push_back(mk(1, 2, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset mid-purchase (credit 2, rr_ptr 1): purchase and pointer discarded.
        apply(mk(1, 2, 'h08, 0, 2, 2, 0, 0, 1, 1, 0, 0), 100);
        apply(mk(0, 0, 'h00, 0, 2, 0, 0, 0, 0, 0, 0, 0), 101);
        apply(mk(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 102);
        apply(mk(1, 3, 'h05, 0, 1, 1, 0, 0, 1, 0, 0, 0), 103);
        apply(mk(1, 1, 'h02, 0, 1, 2, 0, 0, 1, 0, 0, 0), 104);
        apply(mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0), 105);

        // Machine fails to sell in SETTLE: mismatch sets and sticks.
        apply(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 200);
        apply(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0), 201);
        apply(mk(1, 1, 'h02, 0, 1, 2, 0, 0, 1, 0, 0, 0), 202);
        apply(mk(1, 0, 'h00, 1, 0, 0, 1, 0, 0, 0, 0, 1), 203);
        apply(mk(1, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1), 204);

        // Machine sells early during OWN: mismatch sets until reset.
        apply(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 300);
        apply(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 0), 301);
        apply(mk(1, 1, 'h01, 2, 1, 1, 0, 0, 1, 0, 0, 1), 302);
        apply(mk(1, 1, 'h01, 0, 1, 1, 0, 0, 1, 0, 0, 1), 303);
        apply(mk(1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0, 0, 1), 304);
        apply(mk(0, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 305);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
